// File: rtl/mem_loader.sv
// mem_loader -- host-driven loader for the instruction and data memories.
//
// Takes a 32-bit command/data word stream from a host. A header word selects
// an operation (load IMEM, load DMEM, dump DMEM, run CPU), a 10-bit word base
// address and a 16-bit count. Load operations write the following `count`
// words to consecutive word addresses. Dump reads DMEM back onto the out_*
// stream. Run raises cpu_enable for `count` cycles.
//
// Optional feature: define MEM_LOADER_READBACK_EN to build the DMEM dump path
// (RD_REQ/RD_WAIT/RD_OUT). Without it, op 10 is a no-op and out_valid,
// out_data and ren_ext_2 are tied to 0.
//
// Ports:
//   clk, arst_n                          clock, async active-low reset
//   in_valid/in_ready/in_data[31:0]      host command/data stream (input)
//   out_valid/out_ready/out_data[31:0]   readback stream (output)
//   addr_ext, wen_ext, ren_ext,
//   wdata_ext, rdata_ext                 instruction-memory port
//   addr_ext_2, wen_ext_2, ren_ext_2,
//   wdata_ext_2, rdata_ext_2             data-memory port
//   cpu_enable                           CPU run enable
//   busy                                 high whenever the FSM is not idle
module mem_loader (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  input  logic [31:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
`ifdef MEM_LOADER_READBACK_EN
    , S_RD_REQ,
    S_RD_WAIT,
    S_RD_OUT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  waddr_q, waddr_d;
  logic [15:0] count_q, count_d;
  logic        tgt_q, tgt_d;        // 1: DMEM port, 0: IMEM port
  logic        in_ready_q, in_ready_d;
  logic        wen_q, wen_d;
  logic        wen2_q, wen2_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] addr2_q, addr2_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wdata2_q, wdata2_d;
  logic        cpu_en_q, cpu_en_d;
  logic        accept;
  logic [1:0]  hdr_op;
  logic [9:0]  hdr_base;
  logic [15:0] hdr_count;
  logic        unused_sigs;

`ifdef MEM_LOADER_READBACK_EN
  logic        ren2_q, ren2_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
`endif

  assign accept    = in_valid & in_ready_q;
  assign hdr_op    = in_data[31:30];
  assign hdr_base  = in_data[25:16];
  assign hdr_count = in_data[15:0];

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    count_d  = count_q;
    tgt_d    = tgt_q;
    wen_d    = 1'b0;
    wen2_d   = 1'b0;
    addr_d   = addr_q;
    addr2_d  = addr2_q;
    wdata_d  = wdata_q;
    wdata2_d = wdata2_q;
`ifdef MEM_LOADER_READBACK_EN
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept && hdr_count != 16'd0) begin
          waddr_d = hdr_base;
          count_d = hdr_count;
          tgt_d   = hdr_op[0];
          case (hdr_op)
            2'b00, 2'b01: state_d = S_LOAD;
            2'b11:        state_d = S_RUN;
`ifdef MEM_LOADER_READBACK_EN
            default:      state_d = S_RD_REQ;
`else
            default:      state_d = S_IDLE;
`endif
          endcase
        end
      end
      S_LOAD: begin
        // The write goes out on the cycle after the word is accepted.
        if (accept) begin
          if (tgt_q) begin
            wen2_d   = 1'b1;
            addr2_d  = {20'b0, waddr_q, 2'b00};
            wdata2_d = in_data;
          end else begin
            wen_d    = 1'b1;
            addr_d   = {20'b0, waddr_q, 2'b00};
            wdata_d  = in_data;
          end
          waddr_d = waddr_q + 10'd1;
          count_d = count_q - 16'd1;
          if (count_q == 16'd1) state_d = S_IDLE;
        end
      end
      S_RUN: begin
        count_d = count_q - 16'd1;
        if (count_q == 16'd1) state_d = S_IDLE;
      end
`ifdef MEM_LOADER_READBACK_EN
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // Memory returns data one cycle after the read strobe.
        out_data_d  = rdata_ext_2;
        out_valid_d = 1'b1;
        state_d     = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          waddr_d     = waddr_q + 10'd1;
          count_d     = count_q - 16'd1;
          state_d     = (count_q == 16'd1) ? S_IDLE : S_RD_REQ;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Registered outputs that follow the state are derived from the next
    // state so they line up with the state register.
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    cpu_en_d   = (state_d == S_RUN);
`ifdef MEM_LOADER_READBACK_EN
    ren2_d = (state_d == S_RD_REQ);
    if (ren2_d) addr2_d = {20'b0, waddr_d, 2'b00};
`endif
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      waddr_q    <= '0;
      count_q    <= '0;
      tgt_q      <= 1'b0;
      in_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      wen2_q     <= 1'b0;
      addr_q     <= '0;
      addr2_q    <= '0;
      wdata_q    <= '0;
      wdata2_q   <= '0;
      cpu_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      count_q    <= count_d;
      tgt_q      <= tgt_d;
      in_ready_q <= in_ready_d;
      wen_q      <= wen_d;
      wen2_q     <= wen2_d;
      addr_q     <= addr_d;
      addr2_q    <= addr2_d;
      wdata_q    <= wdata_d;
      wdata2_q   <= wdata2_d;
      cpu_en_q   <= cpu_en_d;
    end
  end

`ifdef MEM_LOADER_READBACK_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ren2_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ren2_q      <= ren2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ren_ext_2   = ren2_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign unused_sigs = ^{rdata_ext, in_data[29:26]};
`else
  assign ren_ext_2   = 1'b0;
  assign out_valid   = 1'b0;
  assign out_data    = '0;
  assign unused_sigs = ^{rdata_ext, in_data[29:26], rdata_ext_2, out_ready};
`endif

  // The IMEM port is write-only from the loader's side.
  assign ren_ext     = 1'b0;
  assign in_ready    = in_ready_q;
  assign addr_ext    = addr_q;
  assign wen_ext     = wen_q;
  assign wdata_ext   = wdata_q;
  assign addr_ext_2  = addr2_q;
  assign wen_ext_2   = wen2_q;
  assign wdata_ext_2 = wdata2_q;
  assign cpu_enable  = cpu_en_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader with IMEM/DMEM behavioural models.
module tb_mem_loader;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] rdata_ext = '0;
  logic [31:0] rdata_ext_2 = '0;
  logic        cpu_enable, busy;

  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  mem_loader dut (
    .clk(clk), .arst_n(arst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory models and event logs.
  logic [31:0] dmem [1024];
  logic [31:0] w_port [$];
  logic [31:0] w_addr [$];
  logic [31:0] w_data [$];
  logic [31:0] o_log  [$];
  int ren2_cnt = 0, cpu_cnt = 0, cpu_err = 0, busy_cnt = 0, excl_err = 0;

  always @(posedge clk) begin
    if (pre_we) dmem[pre_addr] <= pre_data;
    if (wen_ext) begin
      w_port.push_back(32'd0); w_addr.push_back(addr_ext); w_data.push_back(wdata_ext);
    end
    if (wen_ext_2) begin
      dmem[addr_ext_2[11:2]] <= wdata_ext_2;
      w_port.push_back(32'd1); w_addr.push_back(addr_ext_2); w_data.push_back(wdata_ext_2);
    end
    if (ren_ext_2) begin
      rdata_ext_2 <= dmem[addr_ext_2[11:2]];
      ren2_cnt <= ren2_cnt + 1;
    end
    if (cpu_enable) cpu_cnt <= cpu_cnt + 1;
    if (cpu_enable && (in_ready || wen_ext || wen_ext_2 || ren_ext || ren_ext_2))
      cpu_err <= cpu_err + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2)) excl_err <= excl_err + 1;
    if (out_valid && out_ready) o_log.push_back(out_data);
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one word and hold it until the loader accepts it.
  task automatic send(input logic [31:0] w);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, c0, e0, b0, r0, o0;

    // Reset state
    tick(3);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_strobes", {28'b0, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 32'd0);
    check("rst_cpu_en", {31'b0, cpu_enable}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_addr_ext_2", addr_ext_2, 32'd0);
    arst_n = 1'b1;
    tick(1);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    // Three IMEM writes from base 0
    n0 = w_addr.size();
    send(32'h0000_0003);
    check("load_busy", {31'b0, busy}, 32'd1);
    check("load_in_ready", {31'b0, in_ready}, 32'd1);
    send(32'h0000_000A);
    send(32'h0000_000B);
    send(32'h0000_000C);
    tick(2);
    check("imem_nwr", w_addr.size() - n0, 32'd3);
    check("imem_p0", w_port[n0], 32'd0);
    check("imem_a0", w_addr[n0], 32'h0);
    check("imem_d0", w_data[n0], 32'hA);
    check("imem_a1", w_addr[n0+1], 32'h4);
    check("imem_d1", w_data[n0+1], 32'hB);
    check("imem_a2", w_addr[n0+2], 32'h8);
    check("imem_d2", w_data[n0+2], 32'hC);
    check("imem_busy_done", {31'b0, busy}, 32'd0);

    // DMEM load wrapping from word 1023 to word 0
    n0 = w_addr.size();
    send(32'h43FF_0002);
    send(32'h0000_0011);
    send(32'h0000_0022);
    tick(2);
    check("dmem_nwr", w_addr.size() - n0, 32'd2);
    check("dmem_p0", w_port[n0], 32'd1);
    check("dmem_a0", w_addr[n0], 32'h0000_0FFC);
    check("dmem_d0", w_data[n0], 32'h11);
    check("dmem_a1_wrap", w_addr[n0+1], 32'h0);
    check("dmem_d1", w_data[n0+1], 32'h22);

    // Reserved header bits set: still a DMEM load at base 7
    n0 = w_addr.size();
    send(32'h7C07_0001);
    send(32'h0000_0055);
    tick(2);
    check("rsv_nwr", w_addr.size() - n0, 32'd1);
    check("rsv_port", w_port[n0], 32'd1);
    check("rsv_addr", w_addr[n0], 32'h1C);
    check("rsv_data", w_data[n0], 32'h55);

    // Run for 4 cycles
    c0 = cpu_cnt;
    e0 = cpu_err;
    n0 = w_addr.size();
    send(32'hC000_0004);
    check("run_cpu_en", {31'b0, cpu_enable}, 32'd1);
    check("run_in_ready", {31'b0, in_ready}, 32'd0);
    tick(8);
    check("run_cycles", cpu_cnt - c0, 32'd4);
    check("run_no_activity", cpu_err - e0, 32'd0);
    check("run_no_writes", w_addr.size() - n0, 32'd0);
    check("run_cpu_off", {31'b0, cpu_enable}, 32'd0);
    check("run_idle_ready", {31'b0, in_ready}, 32'd1);

    // Zero-count header is a no-op
    b0 = busy_cnt;
    n0 = w_addr.size();
    r0 = ren2_cnt;
    send(32'h0000_0000);
    tick(3);
`ifndef MEM_LOADER_READBACK_EN
    // Dump is a no-op without the readback path
    send(32'h8000_0001);
    tick(3);
    check("nord_out_valid", {31'b0, out_valid}, 32'd0);
    check("nord_out_data", out_data, 32'd0);
`endif
    check("noop_busy", busy_cnt - b0, 32'd0);
    check("noop_writes", w_addr.size() - n0, 32'd0);
    check("noop_reads", ren2_cnt - r0, 32'd0);

`ifdef MEM_LOADER_READBACK_EN
    // DMEM dump with backpressure
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 10'd5; pre_data = 32'hDEAD_BEEF;
    @(negedge clk);
    pre_addr = 10'd6; pre_data = 32'h1234_5678;
    @(negedge clk);
    pre_we = 1'b0;
    out_ready = 1'b0;
    r0 = ren2_cnt;
    o0 = o_log.size();
    send(32'h8005_0002);
    tick(10);
    check("rd_valid_held", {31'b0, out_valid}, 32'd1);
    check("rd_data_held", out_data, 32'hDEAD_BEEF);
    check("rd_single_ren", ren2_cnt - r0, 32'd1);
    check("rd_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick(8);
    check("rd_nwords", o_log.size() - o0, 32'd2);
    check("rd_word0", o_log[o0], 32'hDEAD_BEEF);
    check("rd_word1", o_log[o0+1], 32'h1234_5678);
    check("rd_nren", ren2_cnt - r0, 32'd2);
    check("rd_busy_done", {31'b0, busy}, 32'd0);
    out_ready = 1'b0;
`endif

    // Reset in the middle of a 3-word load
    n0 = w_addr.size();
    send(32'h0000_0003);
    send(32'h0000_0001);
    @(negedge clk);
    arst_n   = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0000_0002;
    tick(1);
    check("mid_rst_wen", {31'b0, wen_ext}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    tick(2);
    arst_n   = 1'b1;
    in_valid = 1'b0;
    tick(1);
    check("after_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("after_rst_busy", {31'b0, busy}, 32'd0);
    tick(5);
    check("after_rst_nwr", w_addr.size() - n0, 32'd1);
    check("after_rst_d0", w_data[n0], 32'h1);
    send(32'h0000_0001);
    send(32'h0000_0077);
    tick(2);
    check("reload_addr", w_addr[n0+1], 32'h0);
    check("reload_data", w_data[n0+1], 32'h77);

    check("port_exclusive", excl_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
